// File: rtl/checkpoint_requester.sv
// Checkpoint requester: queues checkpoints from fetch and pushes them into the
// checkpoint buffer, returning the allocated id to fetch one cycle after each push.

package checkpoint_pkg;
    localparam int RAT_MAP_WIDTH = 8;
    localparam int HISTORY_WIDTH = 8;

    typedef struct packed {
        logic [RAT_MAP_WIDTH-1:0] rat_valid;
        logic [RAT_MAP_WIDTH-1:0] rat_visible;
        logic [HISTORY_WIDTH-1:0] global_history;
        logic [HISTORY_WIDTH-1:0] local_history;
    } checkpoint_t;
endpackage

`ifndef CHECKPOINT_ID_WIDTH
`define CHECKPOINT_ID_WIDTH 4
`endif

module checkpoint_requester
    import checkpoint_pkg::*;
#(
    parameter int REQ_FIFO_DEPTH  = 2,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            fetch_req_valid,
    input  checkpoint_t                     fetch_req_data,
    output logic                            fetch_req_ready,
    output logic                            fetch_rsp_valid,
    output logic [`CHECKPOINT_ID_WIDTH-1:0] fetch_rsp_id,
    input  logic [`CHECKPOINT_ID_WIDTH-1:0] cpbuf_fetch_new_id,
    input  logic                            cpbuf_fetch_new_id_valid,
    output checkpoint_t                     fetch_cpbuf_data,
    output logic                            fetch_cpbuf_push,
    input  logic                            commit_cpbuf_flush,
    output logic [STALL_CNT_WIDTH-1:0]      stall_cnt
);
    localparam int AW = $clog2(REQ_FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;
    localparam logic [STALL_CNT_WIDTH-1:0] STALL_ONE = 1;

    checkpoint_t queue_mem [REQ_FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        full;
    logic        empty;
    logic        push;
    logic        accept;
    logic        rsp_valid_q;
    logic [`CHECKPOINT_ID_WIDTH-1:0] rsp_id_q;
    logic [STALL_CNT_WIDTH-1:0]      stall_q;

    // The head is gated to zero when empty so the buffer never sees stale data.
    always_comb begin
        empty            = (wr_ptr == rd_ptr);
        full             = (wr_ptr[AW] != rd_ptr[AW]) &&
                           (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        push             = !empty && cpbuf_fetch_new_id_valid && !commit_cpbuf_flush;
        fetch_req_ready  = !commit_cpbuf_flush && (!full || push);
        accept           = fetch_req_valid && fetch_req_ready;
        fetch_cpbuf_data = empty ? '0 : queue_mem[rd_ptr[AW-1:0]];
        fetch_cpbuf_push = push;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            queue_mem[wr_ptr[AW-1:0]] <= fetch_req_data;
        end
    end

    // A flush simply snaps the read pointer onto the write pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (commit_cpbuf_flush) begin
                rd_ptr <= wr_ptr;
            end else if (push) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            rsp_valid_q <= push;
            if (push) begin
                rsp_id_q <= cpbuf_fetch_new_id;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else if (!empty && !cpbuf_fetch_new_id_valid && !commit_cpbuf_flush &&
                     (stall_q != '1)) begin
            stall_q <= stall_q + STALL_ONE;
        end
    end

    assign fetch_rsp_valid = rsp_valid_q;
    assign fetch_rsp_id    = rsp_id_q;
    assign stall_cnt       = stall_q;

endmodule

// File: tb/tb_checkpoint_requester.sv
// Randomised and directed bench for checkpoint_requester against a queue-based model.

`ifndef CHECKPOINT_ID_WIDTH
`define CHECKPOINT_ID_WIDTH 4
`endif

module tb_checkpoint_requester;
    import checkpoint_pkg::*;

    localparam int DEPTH = 2;
    localparam int IDW   = `CHECKPOINT_ID_WIDTH;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            fetch_req_valid = 1'b0;
    checkpoint_t     fetch_req_data = '0;
    logic [IDW-1:0]  cpbuf_fetch_new_id = '0;
    logic            cpbuf_fetch_new_id_valid = 1'b0;
    logic            commit_cpbuf_flush = 1'b0;

    logic            fetch_req_ready;
    logic            fetch_rsp_valid;
    logic [IDW-1:0]  fetch_rsp_id;
    checkpoint_t     fetch_cpbuf_data;
    logic            fetch_cpbuf_push;
    logic [15:0]     stall_cnt;

    logic            ready_small;
    logic            rsp_valid_small;
    logic [IDW-1:0]  rsp_id_small;
    checkpoint_t     data_small;
    logic            push_small;
    logic [3:0]      stall_small;

    checkpoint_t     model_q[$];
    bit              exp_rsp_valid;
    logic [IDW-1:0]  exp_rsp_id;
    longint          stall_count;
    logic [IDW-1:0]  cp_id;
    int              errors = 0;
    int              checks = 0;

    always #5 clk = ~clk;

    checkpoint_requester #(.REQ_FIFO_DEPTH(DEPTH), .STALL_CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .fetch_req_valid(fetch_req_valid), .fetch_req_data(fetch_req_data),
        .fetch_req_ready(fetch_req_ready),
        .fetch_rsp_valid(fetch_rsp_valid), .fetch_rsp_id(fetch_rsp_id),
        .cpbuf_fetch_new_id(cpbuf_fetch_new_id),
        .cpbuf_fetch_new_id_valid(cpbuf_fetch_new_id_valid),
        .fetch_cpbuf_data(fetch_cpbuf_data), .fetch_cpbuf_push(fetch_cpbuf_push),
        .commit_cpbuf_flush(commit_cpbuf_flush), .stall_cnt(stall_cnt)
    );

    checkpoint_requester #(.REQ_FIFO_DEPTH(DEPTH), .STALL_CNT_WIDTH(4)) dut_small (
        .clk(clk), .rst(rst),
        .fetch_req_valid(fetch_req_valid), .fetch_req_data(fetch_req_data),
        .fetch_req_ready(ready_small),
        .fetch_rsp_valid(rsp_valid_small), .fetch_rsp_id(rsp_id_small),
        .cpbuf_fetch_new_id(cpbuf_fetch_new_id),
        .cpbuf_fetch_new_id_valid(cpbuf_fetch_new_id_valid),
        .fetch_cpbuf_data(data_small), .fetch_cpbuf_push(push_small),
        .commit_cpbuf_flush(commit_cpbuf_flush), .stall_cnt(stall_small)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic longint saturate(input longint count, input int width);
        longint limit;
        limit = (longint'(1) << width) - 1;
        return (count > limit) ? limit : count;
    endfunction

    function automatic checkpoint_t mk(input logic [7:0] gh);
        checkpoint_t c;
        c.rat_valid      = 8'($urandom);
        c.rat_visible    = 8'($urandom);
        c.global_history = gh;
        c.local_history  = 8'($urandom);
        return c;
    endfunction

    // One clock cycle: drive, check against the model, then advance the model.
    task automatic applyStimulus(input bit valid, input checkpoint_t data,
                                 input bit id_valid, input bit flush);
        bit exp_push;
        bit exp_ready;
        bit exp_accept;
        bit exp_stall;
        @(negedge clk);
        fetch_req_valid          = valid;
        fetch_req_data           = data;
        cpbuf_fetch_new_id       = cp_id;
        cpbuf_fetch_new_id_valid = id_valid;
        commit_cpbuf_flush       = flush;
        #1;
        exp_push   = (model_q.size() > 0) && id_valid && !flush;
        exp_ready  = !flush && ((model_q.size() < DEPTH) || exp_push);
        exp_accept = valid && exp_ready;
        exp_stall  = (model_q.size() > 0) && !id_valid && !flush;
        checkOutput("ready", 64'(fetch_req_ready), 64'(exp_ready));
        checkOutput("push", 64'(fetch_cpbuf_push), 64'(exp_push));
        checkOutput("push_small", 64'(push_small), 64'(exp_push));
        if (exp_push) begin
            checkOutput("push_data", 64'(fetch_cpbuf_data), 64'(model_q[0]));
        end
        checkOutput("rsp_valid", 64'(fetch_rsp_valid), 64'(exp_rsp_valid));
        if (exp_rsp_valid) begin
            checkOutput("rsp_id", 64'(fetch_rsp_id), 64'(exp_rsp_id));
        end
        checkOutput("stall16", 64'(stall_cnt), 64'(saturate(stall_count, 16)));
        checkOutput("stall4", 64'(stall_small), 64'(saturate(stall_count, 4)));
        @(posedge clk);
        if (exp_push) begin
            void'(model_q.pop_front());
            exp_rsp_id = cp_id;
            cp_id      = cp_id + 1'b1;
        end
        if (exp_accept) begin
            model_q.push_back(data);
        end
        if (flush) begin
            model_q.delete();
        end
        exp_rsp_valid = exp_push;
        if (exp_stall) begin
            stall_count++;
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        fetch_req_valid    = 1'b0;
        commit_cpbuf_flush = 1'b0;
        rst                = 1'b0;
        #1;
        checkOutput("rst_ready", 64'(fetch_req_ready), 64'd1);
        checkOutput("rst_push", 64'(fetch_cpbuf_push), 64'd0);
        checkOutput("rst_rsp_valid", 64'(fetch_rsp_valid), 64'd0);
        checkOutput("rst_rsp_id", 64'(fetch_rsp_id), 64'd0);
        checkOutput("rst_stall", 64'(stall_cnt), 64'd0);
        checkOutput("rst_stall4", 64'(stall_small), 64'd0);
        checkOutput("rst_data", 64'(fetch_cpbuf_data), 64'd0);
        model_q.delete();
        exp_rsp_valid = 1'b0;
        exp_rsp_id    = '0;
        stall_count   = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        checkpoint_t a, b, c;
        cp_id = '0;
        exp_rsp_valid = 1'b0;
        exp_rsp_id = '0;
        stall_count = 0;

        doReset();

        // Single request, push next cycle, response the cycle after.
        applyStimulus(1, mk(8'd1), 1, 0);
        repeat (2) applyStimulus(0, mk(8'd0), 1, 0);

        // Three back-to-back requests with ids 0, 1, 2.
        doReset();
        cp_id = '0;
        applyStimulus(1, mk(8'd1), 1, 0);
        applyStimulus(1, mk(8'd3), 1, 0);
        applyStimulus(1, mk(8'd7), 1, 0);
        repeat (3) applyStimulus(0, mk(8'd0), 1, 0);

        // Buffer full: two accepted, third held until drain begins.
        a = mk(8'd11); b = mk(8'd12); c = mk(8'd13);
        applyStimulus(1, a, 0, 0);
        applyStimulus(1, b, 0, 0);
        repeat (3) applyStimulus(1, c, 0, 0);
        applyStimulus(1, c, 1, 0);
        repeat (3) applyStimulus(0, mk(8'd0), 1, 0);

        // Flush with two queued and a push on the previous cycle.
        doReset();
        applyStimulus(1, mk(8'd21), 0, 0);
        applyStimulus(1, mk(8'd22), 0, 0);
        applyStimulus(1, mk(8'd23), 1, 0);
        applyStimulus(1, mk(8'd24), 1, 1);
        applyStimulus(0, mk(8'd0), 1, 0);
        applyStimulus(1, mk(8'd25), 1, 0);
        repeat (2) applyStimulus(0, mk(8'd0), 1, 0);

        // Long stall saturates the narrow counter.
        applyStimulus(1, mk(8'd31), 0, 0);
        applyStimulus(1, mk(8'd32), 0, 0);
        repeat (20) applyStimulus(0, mk(8'd0), 0, 0);
        checkOutput("stall4_sat", 64'(stall_small), 64'd15);

        // Reset while full, then nothing pushes until a new request arrives.
        doReset();
        applyStimulus(0, mk(8'd0), 1, 0);
        applyStimulus(1, mk(8'd41), 1, 0);
        repeat (2) applyStimulus(0, mk(8'd0), 1, 0);

        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 9) < 6), mk(8'($urandom)),
                          ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
